// File: rtl/demux_pkg.sv
// Shared route codes and lane count for the 1-to-4 demultiplexer.
// Imported by the RTL and by the bench so both agree on the select encoding.
package demux_pkg;
    localparam int NUM_LANES = 4;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;
endpackage

// File: rtl/decoder_2_4.sv
// Combinational 2-to-4 one-hot decoder with enable; all-zero output when disabled.
module decoder_2_4
    import demux_pkg::*;
(
    input  logic [1:0] sel,
    input  logic       en,
    output logic [3:0] onehot
);

    always_comb begin
        onehot = 4'b0000;
        if (en) begin
            unique case (sel)
                SEL_A: onehot = 4'b0001;
                SEL_B: onehot = 4'b0010;
                SEL_C: onehot = 4'b0100;
                SEL_D: onehot = 4'b1000;
                default: onehot = 4'b0000;
            endcase
        end
    end

endmodule

// File: rtl/demux_1_4.sv
// Registered 1-to-4 demultiplexer: routes in to the selected output for one cycle,
// zeroes the rest, and strobes a one-hot valid_out alongside.
module demux_1_4
    import demux_pkg::*;
#(
    parameter int bus_size = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [1:0]          select,
    input  logic [bus_size-1:0] in,
    output logic [bus_size-1:0] a,
    output logic [bus_size-1:0] b,
    output logic [bus_size-1:0] c,
    output logic [bus_size-1:0] d,
    output logic [3:0]          valid_out
);

    logic [NUM_LANES-1:0]               hot;
    logic [NUM_LANES-1:0][bus_size-1:0] route_d;
    logic [NUM_LANES-1:0][bus_size-1:0] route_q;
    logic [NUM_LANES-1:0]               vld_q;

    decoder_2_4 u_dec (
        .sel    (select),
        .en     (in_valid),
        .onehot (hot)
    );

    // Each lane passes in only when its decode bit is set, so idle lanes load zero.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign route_d[g] = {bus_size{hot[g]}} & in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            route_q <= '0;
            vld_q   <= '0;
        end else begin
            route_q <= route_d;
            vld_q   <= hot;
        end
    end

    assign a         = route_q[0];
    assign b         = route_q[1];
    assign c         = route_q[2];
    assign d         = route_q[3];
    assign valid_out = vld_q;

endmodule

// File: tb/tb_demux_1_4.sv
// Scoreboard bench for demux_1_4 at bus_size 4 and 32 driven from a shared stimulus.
module tb_demux_1_4;
    import demux_pkg::*;

    typedef struct packed {
        logic [3:0][31:0] dat;
        logic [3:0]       vo;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  select = 2'b00;
    logic [31:0] din = '0;

    logic [3:0]  a4, b4, c4, d4, vo4;
    logic [31:0] a32, b32, c32, d32;
    logic [3:0]  vo32;

    int   checks = 0;
    int   failures = 0;
    exp_t expq[$];

    always #5 clk = ~clk;

    demux_1_4 #(.bus_size(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .select(select), .in(din[3:0]),
        .a(a4), .b(b4), .c(c4), .d(d4), .valid_out(vo4)
    );

    demux_1_4 #(.bus_size(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .select(select), .in(din),
        .a(a32), .b(b32), .c(c32), .d(d32), .valid_out(vo32)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the selected output carries the data, everything else is zero.
    function automatic exp_t model(input logic v, input logic [1:0] s, input logic [31:0] x);
        exp_t e;
        e = '0;
        if (v) begin
            e.dat[s] = x;
            e.vo[s]  = 1'b1;
        end
        return e;
    endfunction

    task automatic compare_all(input exp_t e);
        chk("dut4.a", {28'd0, a4}, {28'd0, e.dat[0][3:0]});
        chk("dut4.b", {28'd0, b4}, {28'd0, e.dat[1][3:0]});
        chk("dut4.c", {28'd0, c4}, {28'd0, e.dat[2][3:0]});
        chk("dut4.d", {28'd0, d4}, {28'd0, e.dat[3][3:0]});
        chk("dut4.valid_out", {28'd0, vo4}, {28'd0, e.vo});
        chk("dut32.a", a32, e.dat[0]);
        chk("dut32.b", b32, e.dat[1]);
        chk("dut32.c", c32, e.dat[2]);
        chk("dut32.d", d32, e.dat[3]);
        chk("dut32.valid_out", {28'd0, vo32}, {28'd0, e.vo});
    endtask

    // Monitor: outputs are registered, so each rising edge retires one expectation.
    always @(posedge clk) begin
        #1;
        if (!rst && expq.size() > 0) compare_all(expq.pop_front());
    end

    task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] x);
        @(negedge clk);
        in_valid = v;
        select   = s;
        din      = x;
        expq.push_back(model(v, s, x));
    endtask

    initial begin
        int wait_cyc;
        #1;
        compare_all('0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        drive(1'b1, SEL_A, 32'h0000_000A);
        drive(1'b1, SEL_B, 32'h0000_000B);
        drive(1'b1, SEL_C, 32'h0000_000F);
        drive(1'b1, SEL_D, 32'h0000_0001);
        drive(1'b0, SEL_C, 32'hFFFF_FFFF);
        drive(1'b1, SEL_D, 32'h0000_0000);
        drive(1'b1, SEL_A, 32'hDEAD_BEEF);
        drive(1'b1, SEL_A, 32'h0000_000A);

        // Mid-cycle reset with a=1010 held: outputs clear at once.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        compare_all('0);
        // Discard the pending in-flight value; reset also ignores new inputs.
        expq.delete();
        @(negedge clk);
        in_valid = 1'b1;
        select   = SEL_B;
        din      = 32'h1234_5678;
        @(posedge clk);
        #1;
        compare_all('0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        expq.push_back(model(1'b0, select, din));
        drive(1'b0, SEL_A, 32'hFFFF_FFFF);

        for (int i = 0; i < 200; i++)
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom);

        drive(1'b0, SEL_A, 32'h0);
        wait_cyc = 0;
        while (expq.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            #2;
            wait_cyc++;
        end
        if (expq.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", expq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_1_4.md
DEMUX_1_4 -- requirements
Module: demux_1_4

Interface
REQ-001 Parameter bus_size, default 4, width of the data input and of each data output; SHALL be legal for any value >= 1.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  qualifies in and select for the current cycle.
REQ-005 select  input  2  route code: 00->a, 01->b, 10->c, 11->d.
REQ-006 in  input  bus_size  data to be routed.
REQ-007 a  output  bus_size  route 00 data, registered.
REQ-008 b  output  bus_size  route 01 data, registered.
REQ-009 c  output  bus_size  route 10 data, registered.
REQ-010 d  output  bus_size  route 11 data, registered.
REQ-011 valid_out  output  4  one-hot strobe, bit0=a, bit1=b, bit2=c, bit3=d, registered.

Function
REQ-012 Latency SHALL be exactly one clock: values sampled at edge N SHALL appear on the outputs after edge N and stay until edge N+1.
REQ-013 With in_valid=1, the output named by select SHALL load in; the other three data outputs SHALL load all-zeros.
REQ-014 With in_valid=1, valid_out SHALL load the one-hot decode of select; exactly one bit SHALL be set.
REQ-015 With in_valid=0, all four data outputs SHALL load zero and valid_out SHALL load 4'b0000, whatever select and in are.
REQ-016 Data SHALL pass bit-exact with no truncation, extension or inversion for every bus_size.
REQ-017 A change of select on consecutive cycles SHALL move data to the new output on the next edge; the previous output SHALL return to zero on that same edge, and no cycle SHALL show two outputs holding routed data.
REQ-018 in = all-zeros with in_valid=1 SHALL still set the matching valid_out bit, so zero data is distinguishable from idle.
REQ-019 No combinational path SHALL exist from any input to any output.

Reset
REQ-020 rst=1 SHALL force a, b, c, d to all-zeros and valid_out to 4'b0000 immediately, without waiting for a clock edge.
REQ-021 While rst=1, outputs SHALL hold reset values and ignore in_valid, select and in.
REQ-022 After rst falls, the first rising edge SHALL sample inputs normally per REQ-013 to REQ-015.
REQ-023 A reset asserted mid-stream SHALL discard the in-flight value; it SHALL NOT reappear after release.

Structure
REQ-024 Route codes SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_D=2'b11 SHALL be constants in a shared package, demux_pkg, used by RTL and bench.
REQ-025 The select-to-one-hot decode SHALL be a separate combinational sub-module, decoder_2_4 (2-bit in, 4-bit one-hot out, enable input tied to in_valid).
REQ-026 demux_1_4 SHALL hold only the decoder instance, the per-output gating and the output registers.

Verification
REQ-027 bus_size=4, in_valid=1, select=00, in=1010, one edge -> a=1010, b=c=d=0000, valid_out=0001.
REQ-028 Next cycles select=01 in=1011, then 10 in=1111, then 11 in=0001 -> after each edge b=1011 / c=1111 / d=0001 in turn, all other outputs 0000, valid_out 0010 / 0100 / 1000.
REQ-029 in_valid=0, select=10, in=1111 -> after the edge all outputs 0000, valid_out=0000.
REQ-030 With a=1010 held, pulse rst between edges -> all outputs 0000 at once; after release with in_valid=0, outputs stay 0000.
REQ-031 in_valid=1, select=11, in=0000 -> d=0000, valid_out=1000.
REQ-032 Repeat REQ-027 with bus_size=32, in=32'hDEADBEEF -> a=32'hDEADBEEF, others zero.
